// File: rtl/hist_eq_pkg.sv
// Shared types and constants for the histogram equalizer.
// Holds the FSM state enum, bin-width/total helpers and latency.
package hist_eq_pkg;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_ACCUM,
    ST_CDF,
    ST_SWAP
  } state_e;

  localparam int LAT       = 3;
  localparam int CDF_DRAIN = 1;

  function automatic int total_f(input int h, input int v);
    return h * v;
  endfunction

  function automatic int pw_f(input int h, input int v);
    return $clog2(h * v + 1);
  endfunction

endpackage

// File: rtl/hist_eq_channel.sv
// One colour channel: histogram RAM with RMW forwarding, CDF normaliser, two table banks.
// Ports: pix_i stage-1 sample, inc/clr/cdf controls from the shared FSM, lut_o table read.
module hist_eq_channel
  import hist_eq_pkg::*;
#(
  parameter int H_DISP = 1024,
  parameter int V_DISP = 768,
  parameter int DW     = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc_v_i,
  input  logic [DW-1:0] pix_i,
  input  logic          clr_en_i,
  input  logic [DW-1:0] clr_a_i,
  input  logic          cdf_rd_i,
  input  logic          cdf_clr_i,
  input  logic          bank_i,
  output logic [DW-1:0] lut_o
);

  localparam int NB  = 1 << DW;
  localparam int PW  = pw_f(H_DISP, V_DISP);
  localparam int TOT = total_f(H_DISP, V_DISP);
  localparam int MW  = PW + DW;

  logic [PW-1:0] hist_mem [NB];
  logic [DW-1:0] lut_mem [2][NB];

  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] cdf_q, cdf_d;
  logic          inc_v2_q, inc_v2_d;
  logic [DW-1:0] inc_a2_q, inc_a2_d;
  logic          cdf_v_q, cdf_v_d;
  logic [DW-1:0] cdf_a_q, cdf_a_d;
  logic [DW-1:0] lut_q, lut_d;

  logic [DW-1:0] rd_addr;
  logic [PW-1:0] inc_sum;
  logic [PW:0]   cdf_sum;
  logic [PW-1:0] cdf_nx;
  logic [MW-1:0] prod;
  logic [MW-1:0] quo;
  logic [DW-1:0] norm;

  always_comb begin
    rd_addr  = cdf_rd_i ? clr_a_i : pix_i;
    inc_sum  = (&rd_q) ? rd_q : rd_q + PW'(1);
    rd_d     = hist_mem[rd_addr];
    // same bin as the write in flight: take its sum, not the stale RAM word
    if (!cdf_rd_i && inc_v_i && inc_v2_q && inc_a2_q == pix_i)
      rd_d = inc_sum;
    inc_v2_d = inc_v_i & ~cdf_rd_i;
    inc_a2_d = pix_i;
    cdf_v_d  = cdf_rd_i;
    cdf_a_d  = clr_a_i;
    cdf_sum  = {1'b0, cdf_q} + {1'b0, rd_q};
    cdf_nx   = (cdf_sum > (PW+1)'(TOT)) ? PW'(TOT) : cdf_sum[PW-1:0];
    prod     = MW'(cdf_nx) * MW'(NB - 1);
    quo      = prod / MW'(TOT);
    norm     = (quo > MW'(NB - 1)) ? DW'(NB - 1) : quo[DW-1:0];
    cdf_d    = cdf_q;
    if (cdf_clr_i)
      cdf_d = '0;
    else if (cdf_v_q)
      cdf_d = cdf_nx;
    lut_d    = lut_mem[bank_i][pix_i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q     <= '0;
      cdf_q    <= '0;
      inc_v2_q <= 1'b0;
      inc_a2_q <= '0;
      cdf_v_q  <= 1'b0;
      cdf_a_q  <= '0;
      lut_q    <= '0;
    end else begin
      rd_q     <= rd_d;
      cdf_q    <= cdf_d;
      inc_v2_q <= inc_v2_d;
      inc_a2_q <= inc_a2_d;
      cdf_v_q  <= cdf_v_d;
      cdf_a_q  <= cdf_a_d;
      lut_q    <= lut_d;
    end
  end

  // RAMs carry no reset; INIT sweeps the histogram instead
  always_ff @(posedge clk) begin
    if (clr_en_i)
      hist_mem[clr_a_i] <= '0;
    else if (inc_v2_q)
      hist_mem[inc_a2_q] <= inc_sum;
    if (cdf_v_q)
      lut_mem[~bank_i][cdf_a_q] <= norm;
  end

  assign lut_o = lut_q;

endmodule

// File: rtl/hist_eq_multi.sv
// N-channel histogram equalizer: shared FSM, frame counter, eq_en latch, sync delay.
// Ports: RGB_* in, VGA_* out (3-cycle latency), eq_en, lut_valid, stat_overrun.
module hist_eq_multi
  import hist_eq_pkg::*;
#(
  parameter int H_DISP        = 1024,
  parameter int V_DISP        = 768,
  parameter int CH            = 3,
  parameter int DW            = 8,
  parameter int WARMUP_FRAMES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             RGB_hsync,
  input  logic             RGB_vsync,
  input  logic [CH*DW-1:0] RGB_data,
  input  logic             RGB_de,
  input  logic             eq_en,
  output logic             VGA_hsync,
  output logic             VGA_vsync,
  output logic [CH*DW-1:0] VGA_data,
  output logic             VGA_de,
  output logic             lut_valid,
  output logic             stat_overrun
);

  localparam int NB = 1 << DW;
  localparam int CW = DW + 1;
  localparam int FW = $clog2(WARMUP_FRAMES + 1);
  localparam int XW = CH * DW;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [FW-1:0]       frame_q, frame_d;
  logic                bank_q, bank_d;
  logic                eq_q, eq_d;
  logic                vs_prev_q, vs_prev_d;
  logic                ovr_q, ovr_d;
  logic                acc_q, acc_d;
  logic [LAT-1:0][3:0] ctl_q, ctl_d;
  logic [XW-1:0]       px1_q, px1_d;
  logic [XW-1:0]       byp2_q, byp2_d;
  logic [XW-1:0]       out_q, out_d;
  logic [XW-1:0]       lut_rd;

  logic vs_rise, sel;
  logic clr_en, cdf_rd, swap, accum;

  assign vs_rise = RGB_vsync & ~vs_prev_q;
  assign sel     = eq_q & (frame_q == FW'(WARMUP_FRAMES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_INIT;
      cnt_q     <= '0;
      frame_q   <= '0;
      bank_q    <= 1'b0;
      eq_q      <= 1'b0;
      vs_prev_q <= 1'b0;
      ovr_q     <= 1'b0;
      acc_q     <= 1'b0;
      ctl_q     <= '0;
      px1_q     <= '0;
      byp2_q    <= '0;
      out_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      frame_q   <= frame_d;
      bank_q    <= bank_d;
      eq_q      <= eq_d;
      vs_prev_q <= vs_prev_d;
      ovr_q     <= ovr_d;
      acc_q     <= acc_d;
      ctl_q     <= ctl_d;
      px1_q     <= px1_d;
      byp2_q    <= byp2_d;
      out_q     <= out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_INIT:  if (cnt_q == CW'(NB - 1)) state_d = ST_ACCUM;
      ST_ACCUM: if (vs_rise) state_d = ST_CDF;
      ST_CDF:   if (cnt_q == CW'(NB + CDF_DRAIN - 1)) state_d = ST_SWAP;
      ST_SWAP:  state_d = ST_ACCUM;
      default:  state_d = ST_INIT;
    endcase
  end

  always_comb begin
    clr_en = 1'b0;
    cdf_rd = 1'b0;
    swap   = 1'b0;
    accum  = 1'b0;
    unique case (1'b1)
      state_q == ST_INIT:  clr_en = 1'b1;
      state_q == ST_ACCUM: accum = 1'b1;
      state_q == ST_CDF: begin
        // read-then-clear each bin; the drain cycle only writes the table
        cdf_rd = (cnt_q < CW'(NB));
        clr_en = cdf_rd;
      end
      state_q == ST_SWAP:  swap = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    cnt_d = '0;
    if ((state_q == ST_INIT || state_q == ST_CDF) && state_d == state_q)
      cnt_d = cnt_q + CW'(1);
    frame_d = frame_q;
    bank_d  = bank_q;
    if (swap) begin
      bank_d = ~bank_q;
      if (frame_q != FW'(WARMUP_FRAMES))
        frame_d = frame_q + FW'(1);
    end
    eq_d      = vs_rise ? eq_en : eq_q;
    vs_prev_d = RGB_vsync;
    ovr_d     = ovr_q | (RGB_de & ~accum);
    acc_d     = RGB_de & accum;
    ctl_d     = {ctl_q[LAT-2:0], {RGB_de, RGB_hsync, RGB_vsync, sel}};
    px1_d     = RGB_data;
    byp2_d    = px1_q;
    out_d     = ctl_q[1][0] ? lut_rd : byp2_q;
  end

  for (genvar c = 0; c < CH; c++) begin : g_ch
    hist_eq_channel #(
      .H_DISP(H_DISP),
      .V_DISP(V_DISP),
      .DW    (DW)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .inc_v_i  (acc_q),
      .pix_i    (px1_q[c*DW +: DW]),
      .clr_en_i (clr_en),
      .clr_a_i  (cnt_q[DW-1:0]),
      .cdf_rd_i (cdf_rd),
      .cdf_clr_i(accum),
      .bank_i   (bank_q),
      .lut_o    (lut_rd[c*DW +: DW])
    );
  end

  assign VGA_de       = ctl_q[LAT-1][3];
  assign VGA_hsync    = ctl_q[LAT-1][2];
  assign VGA_vsync    = ctl_q[LAT-1][1];
  assign lut_valid    = ctl_q[LAT-1][0];
  assign VGA_data     = out_q;
  assign stat_overrun = ovr_q;

endmodule

// File: tb/tb_hist_eq_multi.sv
// Directed bench for hist_eq_multi on an 8x4 frame (TOTAL=32).
// Expected outputs are hand-derived per frame and queued with a 3-cycle due time.
module tb_hist_eq_multi;

  localparam int CH = 3;
  localparam int DW = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             RGB_hsync = 1'b0;
  logic             RGB_vsync = 1'b0;
  logic [CH*DW-1:0] RGB_data = '0;
  logic             RGB_de = 1'b0;
  logic             eq_en = 1'b1;
  logic             VGA_hsync, VGA_vsync, VGA_de;
  logic [CH*DW-1:0] VGA_data;
  logic             lut_valid, stat_overrun;

  hist_eq_multi #(
    .H_DISP(8), .V_DISP(4), .CH(CH), .DW(DW), .WARMUP_FRAMES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .RGB_hsync(RGB_hsync), .RGB_vsync(RGB_vsync),
    .RGB_data(RGB_data), .RGB_de(RGB_de), .eq_en(eq_en),
    .VGA_hsync(VGA_hsync), .VGA_vsync(VGA_vsync),
    .VGA_data(VGA_data), .VGA_de(VGA_de),
    .lut_valid(lut_valid), .stat_overrun(stat_overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int               due;
    logic [2:0]       sync;
    logic [CH*DW-1:0] data;
    logic             lv;
  } exp_t;

  exp_t q[$];
  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic step(input logic de, input logic [7:0] v, input logic hs,
                      input logic vs, input logic [7:0] e, input logic lv);
    exp_t x;
    @(posedge clk);
    #1;
    RGB_de    = de;
    RGB_hsync = hs;
    RGB_vsync = vs;
    RGB_data  = {CH{v}};
    x.due  = cyc + 3;
    x.sync = {de, hs, vs};
    x.data = {CH{e}};
    x.lv   = lv;
    q.push_back(x);
    @(negedge clk);
    while (q.size() > 0 && q[0].due <= cyc) begin
      x = q.pop_front();
      if (x.due == cyc) begin
        chk("sync", 32'({VGA_de, VGA_hsync, VGA_vsync}), 32'(x.sync));
        if (x.sync[2]) begin
          chk("data", 32'(VGA_data), 32'(x.data));
          chk("lut_valid", 32'(lut_valid), 32'(x.lv));
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0);
  endtask

  // 32 contiguous pixels (a/b blocked or alternating), then a vsync pulse
  task automatic frame(input logic [7:0] a, input logic [7:0] b,
                       input logic alt, input logic [7:0] ea,
                       input logic [7:0] eb, input logic lv,
                       input logic eqm);
    logic [7:0] v, e;
    logic pick;
    for (int j = 0; j < 32; j++) begin
      if (j == 16) eq_en = eqm;
      pick = alt ? j[0] : (j >= 16);
      v = pick ? b : a;
      e = pick ? eb : ea;
      step(1'b1, v, (j % 8) == 7, 1'b0, e, lv);
    end
    idle(4);
    for (int i = 0; i < 4; i++) step(1'b0, 8'd0, 1'b0, 1'b1, 8'd0, 1'b0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_data", 32'(VGA_data), 32'd0);
    chk("rst_de", 32'(VGA_de), 32'd0);
    chk("rst_lutv", 32'(lut_valid), 32'd0);
    chk("rst_ovr", 32'(stat_overrun), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(255);

    // warm-up: two bypassed frames, third equalized (100 -> 255)
    frame(8'd100, 8'd100, 1'b0, 8'd100, 8'd100, 1'b0, 1'b1);
    idle(280);
    chk("ovr_clean", 32'(stat_overrun), 32'd0);
    frame(8'd100, 8'd100, 1'b0, 8'd100, 8'd100, 1'b0, 1'b1);
    idle(280);
    frame(8'd100, 8'd100, 1'b0, 8'd255, 8'd255, 1'b1, 1'b1);
    idle(280);
    // blocked 50/200 through all-100 table
    frame(8'd50, 8'd200, 1'b0, 8'd0, 8'd255, 1'b1, 1'b1);
    idle(280);
    // alternating 50/200 through blocked-run table
    frame(8'd50, 8'd200, 1'b1, 8'd127, 8'd255, 1'b1, 1'b1);
    idle(280);
    // 0 and 120 through alternating table
    frame(8'd0, 8'd120, 1'b0, 8'd0, 8'd127, 1'b1, 1'b1);
    idle(280);
    // TOTAL pixels of one value
    frame(8'd7, 8'd7, 1'b0, 8'd127, 8'd127, 1'b1, 1'b1);
    idle(280);
    frame(8'd6, 8'd7, 1'b0, 8'd0, 8'd255, 1'b1, 1'b1);
    chk("ovr_pre", 32'(stat_overrun), 32'd0);
    // stray pixel during CDF: mapped by the old (all-7) table
    idle(50);
    step(1'b1, 8'd6, 1'b0, 1'b0, 8'd0, 1'b1);
    idle(229);
    chk("ovr_set", 32'(stat_overrun), 32'd1);
    // eq_en drops mid-frame: this frame stays equalized
    frame(8'd6, 8'd7, 1'b0, 8'd127, 8'd255, 1'b1, 1'b0);
    idle(280);
    chk("ovr_sticky", 32'(stat_overrun), 32'd1);
    frame(8'd6, 8'd7, 1'b0, 8'd6, 8'd7, 1'b0, 1'b1);
    idle(280);
    frame(8'd6, 8'd7, 1'b0, 8'd127, 8'd255, 1'b1, 1'b1);
    idle(100);

    // reset in the middle of CDF
    @(posedge clk);
    #1 rst_n = 1'b0;
    q.delete();
    repeat (2) @(negedge clk);
    chk("rst2_lutv", 32'(lut_valid), 32'd0);
    chk("rst2_de", 32'(VGA_de), 32'd0);
    chk("rst2_data", 32'(VGA_data), 32'd0);
    chk("rst2_ovr", 32'(stat_overrun), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    // last INIT cycle: pixel is bypassed and flags overrun
    idle(254);
    step(1'b1, 8'd9, 1'b0, 1'b0, 8'd9, 1'b0);
    idle(2);
    chk("ovr_init", 32'(stat_overrun), 32'd1);
    frame(8'd6, 8'd7, 1'b0, 8'd6, 8'd7, 1'b0, 1'b1);
    idle(280);
    frame(8'd6, 8'd7, 1'b0, 8'd6, 8'd7, 1'b0, 1'b1);
    idle(280);
    frame(8'd6, 8'd7, 1'b0, 8'd127, 8'd255, 1'b1, 1'b1);
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
